// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite definitions: HTRANS transfer codes and the
//               word offsets (HADDR[3:2]) of the input-port register map.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Register word offsets, decoded from HADDR[3:2]
    localparam logic [1:0] c_REG_DATA     = 2'd0;
    localparam logic [1:0] c_REG_STATUS   = 2'd1;
    localparam logic [1:0] c_REG_IRQ_MASK = 2'd2;
    localparam logic [1:0] c_REG_RISE_EN  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/input_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : input_sync_edge
// Description : Multi-stage synchroniser for asynchronous inputs, optional
//               prescaled debounce, and per-bit edge detection steered by a
//               rise/fall select mask.
// Revision    : 1.0 - initial release
// Config      : AHB_INPUT_PORT_DEBOUNCE_EN enables the debounce stage.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               i_port     - raw asynchronous inputs
//               i_rise_en  - per bit: 1 = flag rising edges, 0 = falling
//               o_value    - synchronised (and debounced) input value
//               o_edge     - selected edge seen this cycle (combinational)
// ============================================================================
module input_sync_edge
    import ahb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
`ifdef AHB_INPUT_PORT_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_DIV = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_port,
    input  logic [WIDTH-1:0] i_rise_en,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_edge
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  w_value;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;

    // Stage 0 samples the pad; the last stage is the first safe value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_port};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef AHB_INPUT_PORT_DEBOUNCE_EN
    localparam int c_CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    logic [c_CNT_W-1:0] r_div_cnt;
    logic               r_tick;
    logic [WIDTH-1:0]   r_sample;
    logic [WIDTH-1:0]   r_deb;
    logic [WIDTH-1:0]   w_agree;

    // A bit is accepted only when two consecutive tick samples match.
    assign w_agree = ~(w_sync ^ r_sample);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_sample  <= '0;
            r_deb     <= '0;
        end else begin
            if (r_div_cnt == c_CNT_W'(DEBOUNCE_DIV - 1)) begin
                r_div_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
                r_tick    <= 1'b0;
            end
            if (r_tick) begin
                r_sample <= w_sync;
                r_deb    <= (w_sync & w_agree) | (r_deb & ~w_agree);
            end
        end
    end

    assign w_value = r_deb;
`else
    assign w_value = w_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_value;
        end
    end

    assign w_rise  = w_value & ~r_prev;
    assign w_fall  = ~w_value & r_prev;
    assign o_edge  = (w_rise & i_rise_en) | (w_fall & ~i_rise_en);
    assign o_value = w_value;

endmodule
`default_nettype wire

// File: rtl/ahb_input_port_irq.sv
`default_nettype none
// ============================================================================
// Module      : ahb_input_port_irq
// Description : AHB-Lite slave exposing a synchronised input port with sticky
//               per-bit edge status and a maskable level interrupt.
//               Zero wait states, no error responses.
// Revision    : 1.0 - initial release
// Config      : AHB_INPUT_PORT_DEBOUNCE_EN adds a prescaled debounce stage
//               (parameter DEBOUNCE_DIV) ahead of DATA and edge detection.
// Ports       : HCLK, HRESET (async, active-high)
//               HADDR/HWDATA/HSIZE/HTRANS/HWRITE/HREADY/HSEL - AHB inputs
//               HRDATA, HREADYOUT - AHB outputs
//               iPort - asynchronous external inputs
//               irq   - level interrupt, active-high
// Registers   : 0x0 DATA (RO), 0x4 STATUS (W1C), 0x8 IRQ_MASK (RW),
//               0xC RISE_EN (RW; 1 = rising, 0 = falling)
// ============================================================================
module ahb_input_port_irq
    import ahb_pkg::*;
#(
    parameter int          WIDTH         = 32,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [31:0] RESET_RISE_EN = 32'hFFFF_FFFF
`ifdef AHB_INPUT_PORT_DEBOUNCE_EN
    ,
    parameter int          DEBOUNCE_DIV  = 1000
`endif
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [31:0]      HWDATA,
    input  logic [2:0]       HSIZE,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    input  logic             HSEL,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    input  logic [WIDTH-1:0] iPort,
    output logic             irq
);

    logic             r_rd_en;
    logic             r_wr_en;
    logic [1:0]       r_addr;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_rise_en;
    logic             r_irq;
    logic             w_addr_valid;
    logic [WIDTH-1:0] w_value;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // Size and unmapped address/data bits carry no meaning for this slave.
    assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

    input_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
`ifdef AHB_INPUT_PORT_DEBOUNCE_EN
        ,
        .DEBOUNCE_DIV(DEBOUNCE_DIV)
`endif
    ) u_sync_edge (
        .clk       (HCLK),
        .rst       (HRESET),
        .i_port    (iPort),
        .i_rise_en (r_rise_en),
        .o_value   (w_value),
        .o_edge    (w_edge)
    );

    assign w_addr_valid = HREADY && HSEL && (HTRANS != HTRANS_IDLE);

    // Address phase capture; HREADYOUT is always 1 so every cycle is a
    // fresh address phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= 2'd0;
        end else begin
            r_rd_en <= w_addr_valid && !HWRITE;
            r_wr_en <= w_addr_valid && HWRITE;
            if (w_addr_valid) begin
                r_addr <= HADDR[3:2];
            end
        end
    end

    assign w_clr = (r_wr_en && (r_addr == c_REG_STATUS)) ? HWDATA[WIDTH-1:0] : '0;

    // Control registers and sticky status. A new edge is OR-ed in after the
    // clear so that a simultaneous clear cannot lose it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_status   <= '0;
            r_irq_mask <= '0;
            r_rise_en  <= RESET_RISE_EN[WIDTH-1:0];
            r_irq      <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_edge;
            r_irq    <= |(r_status & r_irq_mask);
            if (r_wr_en) begin
                case (r_addr)
                    c_REG_IRQ_MASK: r_irq_mask <= HWDATA[WIDTH-1:0];
                    c_REG_RISE_EN:  r_rise_en  <= HWDATA[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (r_rd_en) begin
            case (r_addr)
                c_REG_DATA:     w_rdata = 32'(w_value);
                c_REG_STATUS:   w_rdata = 32'(r_status);
                c_REG_IRQ_MASK: w_rdata = 32'(r_irq_mask);
                c_REG_RISE_EN:  w_rdata = 32'(r_rise_en);
                default:        w_rdata = 32'd0;
            endcase
        end
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = 1'b1;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: doc/ahb_input_port_irq.md
Name: ahb_input_port_irq

Overview:
- AHB-Lite slave giving the processor a parametrised-width input port with synchroniser, edge detection, sticky per-bit edge status and a maskable interrupt.
- Successor to the single-register read-only input port.
- Sits on the AHB-Lite bus decoder like any other slave. Drives one level interrupt line to the core/interrupt controller.
- Single-cycle, zero-wait-state bus operation.

Parameters:
- WIDTH, 32: number of input bits, 1..32. Register bits above WIDTH read as 0 and ignore writes.
- SYNC_STAGES, 2: flip-flop stages on iPort before use, 2..4.
- RESET_RISE_EN, all ones: reset value of the RISE_EN register.

Ports:
- HCLK  in  1  bus clock; the only clock
- HRESET  in  1  one clock; reset is asynchronous and active-high
- HADDR  in  32  only [3:2] decoded
- HWDATA  in  32  write data (data phase)
- HSIZE  in  3  ignored; all accesses treated as word
- HTRANS  in  2  transfer type
- HWRITE  in  1  1 = write
- HREADY  in  1  bus ready
- HSEL  in  1  slave select
- HRDATA  out  32  read data
- HREADYOUT  out  1  tied 1
- iPort  in  WIDTH  asynchronous external inputs
- irq  out  1  interrupt request, level, active-high

Behaviour:
- Register map, by HADDR[3:2]:
  - 0 DATA, read-only: synchronised input value.
  - 1 STATUS, read / write-1-to-clear: sticky edge flags.
  - 2 IRQ_MASK, read/write: per-bit interrupt enable. Reset value 0.
  - 3 RISE_EN / FALL_EN control, read/write: bits [WIDTH-1:0] apply to both directions of edge detection. A bit is armed for rising edges when set, and armed for falling edges when clear.
- Address phase:
  - When HREADY && HSEL && HTRANS != IDLE (2'b00), register rd_en = !HWRITE, wr_en = HWRITE, and addr = HADDR[3:2].
  - Otherwise rd_en = wr_en = 0.
- Data phase:
  - Write: on the next HCLK edge with wr_en, update the addressed register from HWDATA.
  - Read: HRDATA is combinational from the registered addr when rd_en. HRDATA = 0 when rd_en = 0.
  - Writes to DATA are ignored.
- HREADYOUT = 1 always. No error response.
- Synchroniser: iPort passes through SYNC_STAGES flops giving sync. A change on iPort appears in DATA reads SYNC_STAGES cycles later.
- Edge detection:
  - prev <= sync every cycle.
  - rise = sync & ~prev, fall = ~sync & prev.
  - edge = (rise & RISE_EN) | (fall & ~RISE_EN).
  - STATUS bit set on the clock after the edge is visible in sync.
- STATUS update each cycle: STATUS <= (STATUS & ~clr) | edge, where clr = HWDATA on a write to address 1, else 0.
  - Simultaneous clear and new edge on the same bit: set wins.
- irq = |(STATUS & IRQ_MASK), registered. Asserts one cycle after the STATUS bit sets, or one cycle after the mask write.
- Reset (asynchronous, HRESET = 1):
  - All sync and prev flops, STATUS, IRQ_MASK, rd_en, wr_en, addr and irq go to 0. RISE_EN goes to RESET_RISE_EN.
  - HRDATA therefore reads 0.
  - Reset mid-transfer abandons the transfer with no register update.
  - On release, prev = 0 and sync = 0, so no spurious edge is flagged until real input data propagates. A high input then produces a rising edge SYNC_STAGES+1 cycles after release, by design.

Optional Feature:
- Macro: AHB_INPUT_PORT_DEBOUNCE_EN.
- When defined:
  - Parameter DEBOUNCE_DIV (default 1000) drives a shared prescaler producing a one-cycle tick every DEBOUNCE_DIV HCLK cycles.
  - Each bit's debounced value updates only when two consecutive tick samples of sync agree.
  - DATA and edge detection use the debounced value. Added latency is up to 2*DEBOUNCE_DIV cycles.
  - The prescaler resets to 0.
- When undefined: no prescaler; debounced value = sync; timing as above.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes: IDLE = 2'b00, BUSY, NONSEQ, SEQ.
  - Register offsets for DATA, STATUS, IRQ_MASK and RISE_EN.
- One natural sub-module: input_sync_edge (synchroniser + optional debounce + edge detect, parametrised on WIDTH and SYNC_STAGES). Bus decode and registers stay in the top.

Test Plan:
- Reset, then read offsets 0x0–0xC with iPort = 0 → reads 0, 0, 0, 0xFFFFFFFF. irq = 0. HREADYOUT = 1 throughout.
- iPort = 0xA5A5_0000, wait 3 cycles, read DATA → 0xA5A5_0000. Read issued fewer than SYNC_STAGES cycles after the change → old value.
- IRQ_MASK = 0x1, iPort[0] 0→1 → STATUS = 0x1 at cycle SYNC_STAGES+1. irq = 1 the next cycle. Write 0x1 to STATUS → STATUS = 0, irq = 0.
- RISE_EN = 0xFFFF_FFFE, iPort[0] 1→0 → STATUS[0] = 1. iPort[1] 1→0 → STATUS[1] stays 0.
- W1C of bit 2 in the same cycle a new edge on bit 2 is detected → STATUS[2] remains 1.
- Assert HRESET asynchronously mid data phase of a write to IRQ_MASK → IRQ_MASK = 0 immediately. The write has no effect after release.
